dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares port A of the main data memory between two requesters: the CPU load/store path and a DMA/loader engine (host upload over SPART, frame-buffer fill).
- Issues at most one access per cycle with a single-cycle grant decision.
- Tracks in-flight reads through the fixed BRAM read latency and returns each read to the requester that issued it.
- CPU has fixed priority; a counter bounds DMA starvation.

Parameters:
- AW, 32, address width of both requesters and the memory port.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles, from mem_en to valid mem_rdata. Legal range 1..4.
- STARVE_LIM, 4, consecutive CPU grants allowed while DMA waits before DMA is forced. Legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  4  byte enables for writes
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  write data
- cpu_stall  out  1  CPU request pending and not granted this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DW  read return data
- dma_req  in  1  DMA access request
- dma_we  in  1  1 = write, 0 = read
- dma_be  in  4  byte enables for writes
- dma_addr  in  AW  word address
- dma_wdata  in  DW  write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  dma_rdata valid
- dma_rdata  out  DW  read return data
- mem_en  out  1  memory port enable
- mem_we  out  4  memory byte write enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- Clocking and reset:
  - One clock domain: clk.
  - Reset is asynchronous, active-low, on rst_n.
  - While rst_n is low: starve_cnt = 0, return-tag pipeline cleared, cpu_rvalid = dma_rvalid = 0.
- Grant logic (combinational, same cycle as the request):
  - cpu_gnt = cpu_req & ~(dma_req & starve_cnt == STARVE_LIM).
  - dma_gnt = dma_req & ~cpu_gnt.
  - cpu_stall = cpu_req & ~cpu_gnt.
- Memory port outputs:
  - Granted requester drives mem_addr and mem_wdata.
  - mem_en = cpu_gnt | dma_gnt.
  - mem_we = be & {4{we}} of the granted requester, else 4'b0.
  - With no grant: mem_addr = 0 and mem_wdata = 0.
- Starvation counter (starve_cnt, 8-bit, registered):
  - Increments when dma_req & cpu_gnt.
  - Clears to 0 when dma_gnt, or when dma_req = 0.
  - Saturates at STARVE_LIM; it never exceeds it.
  - Once at STARVE_LIM, DMA wins the next cycle in which both requesters are active.
- Requester hold rules:
  - A requester holds req, we, be, addr and wdata stable until granted.
  - The arbiter does not latch ungranted requests.
  - Deasserting req before grant is legal; the request is dropped.
- Read return:
  - Granted reads (we = 0) push a tag into an RD_LAT-deep shift register: valid bit plus owner (0 = CPU, 1 = DMA).
  - Writes and idle cycles push an invalid tag.
  - At the pipeline tail, a valid tag with owner CPU pulses cpu_rvalid for one cycle; owner DMA pulses dma_rvalid for one cycle.
  - cpu_rdata and dma_rdata both carry mem_rdata directly (no register).
  - Read data is meaningful only while the matching rvalid is high.
- Pipelining:
  - One access per cycle, back-to-back from either requester.
  - Return order equals issue order.
  - At most one rvalid is high in any cycle.
- Reset mid-operation: in-flight read tags are discarded; no rvalid is produced for them after rst_n rises.
- Simultaneous write from one requester and read return to the other in the same cycle is legal and independent.
- Address range: addresses pass through unmodified. Range decode is done upstream.

Test Plan:
- CPU read alone, addr 0x00000010, RD_LAT = 1: cycle 0 has cpu_stall = 0, mem_en = 1, mem_we = 0, mem_addr = 0x10. Cycle 1 has cpu_rvalid = 1 and cpu_rdata = mem_rdata (memory model returns 0xDEADBEEF).
- Both requesters held active for 12 cycles, STARVE_LIM = 4: CPU granted cycles 0-3, dma_gnt in cycle 4, CPU granted 5-8, dma_gnt in cycle 9. cpu_stall is high exactly in cycles 4 and 9.
- DMA write alone, be = 4'b0011, addr 0x80, wdata 0x12345678: dma_gnt = 1 the same cycle, mem_we = 4'b0011, mem_wdata = 0x12345678. No rvalid follows.
- RD_LAT = 2, alternating reads CPU / DMA / CPU in cycles 0, 1, 2 (single requester per cycle): cpu_rvalid in cycles 2 and 4, dma_rvalid in cycle 3. Data matches the corresponding addresses.
- CPU read issued, rst_n pulled low for 1 cycle before the return: cpu_rvalid never asserts. starve_cnt is 0 after reset.
- DMA requests for 3 cycles while CPU requests, then dma_req drops: starve_cnt reaches 3 and then returns to 0. A subsequent both-requesting sequence starts counting again from 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Data-memory port A arbiter: CPU load/store path vs DMA/loader engine.
// Fixed CPU priority with a bounded DMA starvation window; read returns
// are routed back to the issuing requester through an RD_LAT-deep tag pipe.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cpu_req/we/be/addr/wdata           CPU request (held until granted)
//   cpu_stall, cpu_rvalid, cpu_rdata   CPU stall and read return
//   dma_req/we/be/addr/wdata           DMA request (held until granted)
//   dma_gnt, dma_rvalid, dma_rdata     DMA accept and read return
//   mem_en/we/addr/wdata, mem_rdata    shared BRAM port A
module dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [3:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [3:0]    dma_be,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    logic              cpu_gnt;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic [RD_LAT-1:0] tag_v_q, tag_v_d;
    logic [RD_LAT-1:0] tag_own_q, tag_own_d;

    // Grant and memory port mux.
    always_comb begin
        cpu_gnt   = cpu_req & ~(dma_req & (starve_cnt_q == LIM));
        dma_gnt   = dma_req & ~cpu_gnt;
        cpu_stall = cpu_req & ~cpu_gnt;
        mem_en    = cpu_gnt | dma_gnt;
        mem_we    = 4'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            cpu_gnt: begin
                mem_we    = cpu_be & {4{cpu_we}};
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            dma_gnt: begin
                mem_we    = dma_be & {4{dma_we}};
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    // Counts consecutive CPU wins while DMA is waiting; saturates at LIM.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (dma_gnt || !dma_req) begin
            starve_cnt_d = 8'd0;
        end else if (cpu_gnt && starve_cnt_q != LIM) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    // Tag pipe mirrors BRAM read latency; owner 1 = DMA.
    always_comb begin
        tag_v_d   = '0;
        tag_own_d = '0;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
        tag_v_d[0]   = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
        tag_own_d[0] = dma_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 8'd0;
            tag_v_q      <= '0;
            tag_own_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_v_q      <= tag_v_d;
            tag_own_q    <= tag_own_d;
        end
    end

    assign cpu_rvalid = tag_v_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
    assign dma_rvalid = tag_v_q[RD_LAT-1] & tag_own_q[RD_LAT-1];
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule
